// File: rtl/axi4lite_master_ctl.sv
// Single-outstanding AXI4-Lite master: turns one user write or read command into
// a complete AXI4-Lite transaction, reporting response code, completion and timeout.
module axi4lite_master_ctl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic                      start_write,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_strb,
    input  logic                      start_read,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                resp,
    output logic                      timeout
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, expire;

    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign b_hs   = m_axi_bvalid && m_axi_bready;
    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid && m_axi_rready;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    // Abort fires on the cycle the counter would reach TIMEOUT_CYCLES idle cycles.
    assign expire = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !any_hs && (cnt == CNT_LAST);

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            cnt <= '0;
        end else if (state == IDLE || any_hs) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= IDLE;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            read_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            resp          <= 2'b00;
            timeout       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_write) begin
                        m_axi_awaddr  <= write_addr;
                        m_axi_wdata   <= write_data;
                        m_axi_wstrb   <= write_strb;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= WR_REQ;
                    end else if (start_read) begin
                        m_axi_araddr  <= read_addr;
                        m_axi_arvalid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) m_axi_awvalid <= 1'b0;
                    if (w_hs)  m_axi_wvalid  <= 1'b0;
                    // A channel whose valid is already low has finished its handshake.
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        resp         <= m_axi_bresp;
                        timeout      <= 1'b0;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        read_data    <= m_axi_rdata;
                        resp         <= m_axi_rresp;
                        timeout      <= 1'b0;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Hung slave: drop every valid/ready without waiting for the handshake.
            if (expire) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                resp          <= 2'b10;
                timeout       <= 1'b1;
                done          <= 1'b1;
                state         <= IDLE;
            end
        end
    end

endmodule
